led_ctrl_multi: RTL and testbench

LED_CTRL_MULTI -- requirements
Module: led_ctrl_multi

---
 rtl/led_ctrl_multi.sv | 196 +++++++++++++++++++
 tb/tb_led_ctrl_multi.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_ctrl_multi.sv
// Purpose : CH_NUM independent LED channels, each with a debounced active-low key that
//           steps a LOGIC -> ON -> BLINK -> OFF mode FSM and drives a registered LED.
// Latency : key fall first sampled at edge 1 -> press_pulse after edge DEBOUNCE_CYC+2,
//           mode after edge DEBOUNCE_CYC+3, led_out after edge DEBOUNCE_CYC+4.
// Backpressure: none; all inputs are sampled every cycle and outputs are free-running.
//
// Ports:
//   clk         - single clock, rising edge
//   rst         - synchronous active-high reset
//   a, b        - per-channel logic operands (asynchronous, 2-flop synchronised)
//   key_in      - per-channel mechanical key, 0 = pressed (asynchronous, bouncy)
//   led_out     - registered LED drive, 1 = lit
//   press_pulse - one-cycle strobe per accepted press
//   mode        - channel i mode on bits [2i+1:2i]: 00 LOGIC, 01 ON, 10 BLINK, 11 OFF
//
// Build option: define LED_PWM_EN to dim ON mode with a free-running PWM counter
// (PWM_DUTY on-cycles out of every PWM_PERIOD); otherwise ON mode is a steady 1.
module led_ctrl_multi #(
    parameter int CH_NUM       = 4,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int BLINK_HALF   = 25000000,
    parameter int PWM_PERIOD   = 100,
    parameter int PWM_DUTY     = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH_NUM-1:0]     a,
    input  logic [CH_NUM-1:0]     b,
    input  logic [CH_NUM-1:0]     key_in,
    output logic [CH_NUM-1:0]     led_out,
    output logic [CH_NUM-1:0]     press_pulse,
    output logic [2*CH_NUM-1:0]   mode
);

    // Elaboration-time parameter sanity checks.
    if (DEBOUNCE_CYC < 2) begin : g_chk_db
        $error("DEBOUNCE_CYC must be 2 or more");
    end
    if (BLINK_HALF < 1) begin : g_chk_blink
        $error("BLINK_HALF must be 1 or more");
    end
    if (PWM_PERIOD < 1 || PWM_DUTY > PWM_PERIOD) begin : g_chk_pwm
        $error("PWM_DUTY must not exceed PWM_PERIOD");
    end

    localparam int DB_W = $clog2(DEBOUNCE_CYC);
    localparam int BL_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        MODE_LOGIC = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_OFF   = 2'b11
    } mode_e;

    // Synchroniser chain, packed as {key, b, a}.
    logic [3*CH_NUM-1:0] sync1_q, sync2_q;
    logic [CH_NUM-1:0]   a_s, b_s, key_s;

    logic [DB_W-1:0]     db_cnt_q [CH_NUM];
    logic [DB_W-1:0]     db_cnt_d [CH_NUM];
    logic [CH_NUM-1:0]   stable_q, stable_d;
    logic [CH_NUM-1:0]   pulse_q, pulse_d;
    logic [CH_NUM-1:0]   led_q, led_d;
    mode_e               mode_q [CH_NUM];
    mode_e               mode_d [CH_NUM];

    logic [BL_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic                blink_ph_q, blink_ph_d;
    logic                blink_wrap;
    logic                on_lvl;

    assign a_s   = sync2_q[CH_NUM-1:0];
    assign b_s   = sync2_q[2*CH_NUM-1:CH_NUM];
    assign key_s = sync2_q[3*CH_NUM-1:2*CH_NUM];

`ifdef LED_PWM_EN
    localparam int PW_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam logic [PW_W-1:0] PW_LAST = PW_W'(PWM_PERIOD - 1);
    // One extra bit so PWM_DUTY == PWM_PERIOD still compares as "always on".
    localparam logic [PW_W:0]   PW_DUTY = (PW_W+1)'(PWM_DUTY);

    logic [PW_W-1:0] pwm_cnt_q, pwm_cnt_d;

    assign pwm_cnt_d = (pwm_cnt_q == PW_LAST) ? '0 : pwm_cnt_q + 1'b1;
    assign on_lvl    = ({1'b0, pwm_cnt_q} < PW_DUTY);

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end
`else
    assign on_lvl = 1'b1;
`endif

    // Shared blink timebase; free-runs independently of any channel mode.
    assign blink_wrap  = (blink_cnt_q == BL_LAST);
    assign blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    assign blink_ph_d  = blink_ph_q ^ blink_wrap;

    // Debounce: any cycle matching the stable level restarts the count, so a bounce
    // shorter than DEBOUNCE_CYC never gets accepted. Only a 1->0 acceptance pulses.
    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            db_cnt_d[i] = '0;
            stable_d[i] = stable_q[i];
            pulse_d[i]  = 1'b0;
            if (key_s[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = key_s[i];
                    pulse_d[i]  = ~key_s[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Mode FSM next state and LED next value per channel.
    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            mode_d[i] = mode_q[i];
            led_d[i]  = 1'b0;
            if (pulse_q[i]) begin
                case (mode_q[i])
                    MODE_LOGIC: mode_d[i] = MODE_ON;
                    MODE_ON:    mode_d[i] = MODE_BLINK;
                    MODE_BLINK: mode_d[i] = MODE_OFF;
                    default:    mode_d[i] = MODE_LOGIC;
                endcase
            end
            case (mode_q[i])
                // NAND while the key is held, XOR while released.
                MODE_LOGIC: led_d[i] = (~(a_s[i] & b_s[i]) & ~stable_q[i])
                                     | ((a_s[i] ^ b_s[i]) & stable_q[i]);
                MODE_ON:    led_d[i] = on_lvl;
                MODE_BLINK: led_d[i] = blink_ph_q;
                default:    led_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < CH_NUM; i++) begin
            if (rst) begin
                mode_q[i] <= MODE_LOGIC;
            end else begin
                mode_q[i] <= mode_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Synchronisers and stable levels reset to "released" so a key held
            // through reset needs a full fresh debounce count.
            sync1_q     <= '1;
            sync2_q     <= '1;
            stable_q    <= '1;
            pulse_q     <= '0;
            led_q       <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= {key_in, b, a};
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            pulse_q     <= pulse_d;
            led_q       <= led_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            for (int i = 0; i < CH_NUM; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign led_out     = led_q;
    assign press_pulse = pulse_q;

    always_comb begin
        mode = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            mode[2*i +: 2] = mode_q[i];
        end
    end

endmodule

// File: tb/tb_led_ctrl_multi.sv
// Purpose : directed self-checking bench for led_ctrl_multi (2 channels, short timings).
// Latency : samples outputs 1 time unit after each rising edge; inputs change there too.
// Backpressure: not applicable; every wait is a fixed number of cycles.
module tb_led_ctrl_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] a, b, key_in;
    logic [1:0] led_out, press_pulse;
    logic [3:0] mode;

    int n_checks = 0;
    int n_errors = 0;

    led_ctrl_multi #(
        .CH_NUM       (2),
        .DEBOUNCE_CYC (4),
        .BLINK_HALF   (3),
        .PWM_PERIOD   (4),
        .PWM_DUTY     (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .key_in      (key_in),
        .led_out     (led_out),
        .press_pulse (press_pulse),
        .mode        (mode)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold the masked keys low for 10 cycles, then release for 10 cycles.
    // Returns the number of cycles with any pulse and the first pulse vector seen.
    task automatic press(input logic [1:0] mask, output logic [1:0] pv, output int npulse);
        pv     = 2'b00;
        npulse = 0;
        key_in = ~mask;
        for (int k = 0; k < 10; k++) begin
            step();
            if (press_pulse != 2'b00) begin
                if (npulse == 0) pv = press_pulse;
                npulse++;
            end
        end
        key_in = 2'b11;
        for (int k = 0; k < 10; k++) begin
            step();
            if (press_pulse != 2'b00) npulse++;
        end
    endtask

    logic [1:0]  pv;
    int          np, pc, pe, t, k0;
    logic [11:0] v;
    logic [8:0]  got9, exp9;
    logic [7:0]  v8, e8;

    initial begin
        // ---- reset and LOGIC-mode XOR ----
        rst = 1'b1; a = 2'b11; b = 2'b11; key_in = 2'b11;
        repeat (3) step();
        check_eq("rst_led",   led_out,     2'b00);
        check_eq("rst_mode",  mode,        4'b0000);
        check_eq("rst_pulse", press_pulse, 2'b00);
        rst = 1'b0;
        repeat (3) step();
        check_eq("xor_a11_b11", led_out, 2'b00);
        a = 2'b01;
        repeat (3) step();
        check_eq("xor_a01_b11", led_out, 2'b10);
        a = 2'b10;
        repeat (3) step();
        check_eq("xor_a10_b11", led_out, 2'b01);
        a = 2'b11;
        repeat (3) step();

        // ---- press latency on ch0: key low sampled first at edge 1 ----
        key_in = 2'b10;
        for (int n = 1; n <= 8; n++) begin
            step();
            if (n == 5) check_eq("lat_pulse_e5", press_pulse, 2'b00);
            if (n == 6) begin
                check_eq("lat_pulse_e6", press_pulse, 2'b01);
                check_eq("lat_mode_e6",  mode[1:0],   2'b00);
            end
            if (n == 7) begin
                check_eq("lat_pulse_e7", press_pulse, 2'b00);
                check_eq("lat_mode_e7",  mode[1:0],   2'b01);
                check_eq("lat_led_e7",   led_out[0],  1'b0);
            end
`ifndef LED_PWM_EN
            if (n == 8) check_eq("lat_led_e8", led_out[0], 1'b1);
`endif
        end
        key_in = 2'b11;
        pc = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (press_pulse != 2'b00) pc++;
        end
        check_eq("release_no_pulse", pc, 0);

        // ---- press 2 -> BLINK, check 3-cycle toggling ----
        press(2'b01, pv, np);
        check_eq("p2_npulse", np, 1);
        check_eq("p2_pv",     pv, 2'b01);
        check_eq("p2_mode",   mode[1:0], 2'b10);
        for (int j = 0; j < 12; j++) begin
            step();
            v[j] = led_out[0];
        end
        t = -1;
        for (int j = 1; j <= 3; j++) begin
            if (t < 0 && v[j] != v[j-1]) t = j;
        end
        check_eq("blink_toggle_found", (t > 0) ? 1 : 0, 1);
        if (t < 0) t = 1;
        for (int j = 0; j < 9; j++) begin
            got9[j] = v[t+j];
            exp9[j] = v[t] ^ (((j / 3) % 2) == 1);
        end
        check_eq("blink_period", got9, exp9);

        // ---- press 3 -> OFF, press 4 -> LOGIC ----
        press(2'b01, pv, np);
        check_eq("p3_npulse", np, 1);
        check_eq("p3_mode",   mode[1:0], 2'b11);
        check_eq("off_led",   led_out[0], 1'b0);
        press(2'b01, pv, np);
        check_eq("p4_npulse", np, 1);
        check_eq("p4_mode",   mode[1:0], 2'b00);

        // ---- bounce on ch1: low 3, high 1, low 10; operands 00 (XOR 0, NAND 1) ----
        a = 2'b00; b = 2'b00;
        repeat (3) step();
        pc = 0; pe = 0;
        for (int n = 1; n <= 14; n++) begin
            key_in = (n == 4) ? 2'b11 : 2'b01;
            step();
            if (press_pulse[1]) begin
                pc++;
                pe = n;
            end
            if (press_pulse[0]) pc++;
            if (n == 10) check_eq("bnc_led_xor",  led_out[1], 1'b0);
            if (n == 11) check_eq("bnc_led_nand", led_out[1], 1'b1);
        end
        key_in = 2'b11;
        for (int n = 0; n < 10; n++) begin
            step();
            if (press_pulse != 2'b00) pc++;
        end
        check_eq("bnc_npulse",     pc, 1);
        check_eq("bnc_pulse_edge", pe, 10);
        check_eq("bnc_mode",       mode, 4'b0100);

        // ---- simultaneous presses on both channels ----
        press(2'b11, pv, np);
        check_eq("sim_npulse", np, 1);
        check_eq("sim_pv",     pv, 2'b11);
        check_eq("sim_mode",   mode, 4'b1001);

        // ---- ON mode output on ch0 ----
        for (int j = 0; j < 8; j++) begin
            step();
            v8[j] = led_out[0];
        end
`ifdef LED_PWM_EN
        k0 = -1;
        for (int j = 0; j < 4; j++) begin
            if (k0 < 0 && v8[j]) k0 = j;
        end
        check_eq("pwm_on_found", (k0 >= 0) ? 1 : 0, 1);
        if (k0 < 0) k0 = 0;
        for (int j = 0; j < 8; j++) begin
            e8[j] = (j >= k0) && (((j - k0) % 4) == 0);
        end
`else
        e8 = 8'hFF;
`endif
        check_eq("on_pattern", v8, e8);

        // ---- reset mid-debounce with key held through release ----
        key_in = 2'b10;
        repeat (3) step();
        rst = 1'b1;
        repeat (2) step();
        check_eq("rst2_mode",  mode,        4'b0000);
        check_eq("rst2_pulse", press_pulse, 2'b00);
        check_eq("rst2_led",   led_out,     2'b00);
        rst = 1'b0;
        pc = 0; pe = 0;
        for (int n = 1; n <= 8; n++) begin
            step();
            if (press_pulse != 2'b00) begin
                pc++;
                pe = n;
            end
        end
        check_eq("rst2_npulse",     pc, 1);
        check_eq("rst2_pulse_edge", pe, 6);
        check_eq("rst2_mode_after", mode[1:0], 2'b01);
        key_in = 2'b11;
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
